// File: rtl/ahb_timer_if.sv
// ahb_timer_if -- AHB-Lite responder-side signal bundle for ahb_timer.
//   i_hsel, i_haddr[31:0], i_hburst[2:0], i_hsize[2:0], i_hprot[3:0],
//   i_htrans[1:0], i_hwdata[63:0], i_hwrite, i_hreadyin : master -> timer
//   o_hrdata[63:0], o_hresp, o_hready                    : timer -> master
interface ahb_timer_if;
  logic        i_hsel;
  logic [31:0] i_haddr;
  logic [2:0]  i_hburst;
  logic [2:0]  i_hsize;
  logic [3:0]  i_hprot;
  logic [1:0]  i_htrans;
  logic [63:0] i_hwdata;
  logic        i_hwrite;
  logic        i_hreadyin;
  logic [63:0] o_hrdata;
  logic        o_hresp;
  logic        o_hready;

  modport master (
    output i_hsel, i_haddr, i_hburst, i_hsize, i_hprot, i_htrans,
           i_hwdata, i_hwrite, i_hreadyin,
    input  o_hrdata, o_hresp, o_hready
  );

  modport slave (
    input  i_hsel, i_haddr, i_hburst, i_hsize, i_hprot, i_htrans,
           i_hwdata, i_hwrite, i_hreadyin,
    output o_hrdata, o_hresp, o_hready
  );
endinterface

// File: rtl/ahb_timer.sv
// ahb_timer -- 64-bit compare timer with an AHB-Lite register interface.
//   i_clk    : sole clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : ahb_timer_if.slave (AHB-Lite responder signals)
//   o_irq    : registered compare interrupt (STATUS.match & CTRL.irq_en)
// Registers: 0x00 CTRL {clear_on_match, irq_en, enable}, 0x08 STATUS.match
// (W1C), 0x10 COUNT, 0x18 CMP, 0x20 PRESCALE (only with the macro below).
// Writes are zero-wait, reads take one wait state, bad transfers get a
// two-cycle ERROR.
// Optional feature: define AHB_TIMER_PRESCALER_EN for a PRESCALE register
// and tick divider; otherwise the counter ticks every cycle.
module ahb_timer #(
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  ahb_timer_if.slave bus,
  output logic       o_irq
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ERR1, ERR2} state_e;

  state_e      state_q, state_d;
  logic        hready_q, hready_d;
  logic        hresp_q, hresp_d;
  logic [63:0] hrdata_q, hrdata_d;
  logic        irq_q, irq_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        match_q, match_d;
  logic [63:0] count_q, count_d;
  logic [63:0] cmp_q, cmp_d;
  logic        wr_pend_q, wr_pend_d;
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic [7:0]  wr_be_q, wr_be_d;
  logic [2:0]  rd_idx_q, rd_idx_d;
`ifdef AHB_TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
`endif

  logic        accept, addr_ok, align_ok, valid;
  logic [2:0]  idx;
  logic [7:0]  be;
  logic        tick, count_wr, match_set, w1c;
  logic [63:0] inc, rdata;

  logic unused_bus;
  assign unused_bus = ^{bus.i_hburst, bus.i_hprot, bus.i_haddr[31:6]};

  function automatic logic [63:0] merge(input logic [63:0] old_v,
                                        input logic [63:0] new_v,
                                        input logic [7:0]  lanes);
    logic [63:0] m;
    for (int unsigned i = 0; i < 8; i++) m[8*i +: 8] = {8{lanes[i]}};
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Address-phase decode
  always_comb begin
    accept = bus.i_hsel & bus.i_hreadyin & bus.i_htrans[1];
    idx    = bus.i_haddr[5:3];
`ifdef AHB_TIMER_PRESCALER_EN
    addr_ok = (idx <= 3'd4);
`else
    addr_ok = (idx <= 3'd3);
`endif
    case (bus.i_hsize[1:0])
      2'd0:    begin align_ok = 1'b1;                      be = 8'h01 << bus.i_haddr[2:0]; end
      2'd1:    begin align_ok = ~bus.i_haddr[0];           be = 8'h03 << bus.i_haddr[2:0]; end
      2'd2:    begin align_ok = (bus.i_haddr[1:0] == 2'd0); be = 8'h0F << bus.i_haddr[2:0]; end
      default: begin align_ok = (bus.i_haddr[2:0] == 3'd0); be = 8'hFF; end
    endcase
    valid = addr_ok & ~bus.i_hsize[2] & align_ok;
  end

  always_comb begin
    state_d   = state_q;
    hready_d  = hready_q;
    hresp_d   = hresp_q;
    hrdata_d  = hrdata_q;
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    cmp_d     = cmp_q;
    wr_pend_d = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_be_d   = wr_be_q;
    rd_idx_d  = rd_idx_q;
    rdata     = '0;

    tick = 1'b1;
`ifdef AHB_TIMER_PRESCALER_EN
    prescale_d = prescale_q;
    tick  = (div_q == prescale_q);
    div_d = tick ? '0 : div_q + 1'b1;
`endif

    // A bus write to COUNT replaces the increment (and any match it would make).
    count_wr  = wr_pend_q && (wr_idx_q == 3'd2);
    inc       = count_q + 64'd1;
    match_set = 1'b0;
    if (ctrl_q[0] && tick && !count_wr) begin
      if (inc == cmp_q) begin
        match_set = 1'b1;
        count_d   = ctrl_q[2] ? '0 : inc;
      end else begin
        count_d = inc;
      end
    end

    w1c = 1'b0;
    if (wr_pend_q) begin
      case (wr_idx_q)
        3'd0: if (wr_be_q[0]) ctrl_d = bus.i_hwdata[2:0];
        3'd1: w1c = wr_be_q[0] & bus.i_hwdata[0];
        3'd2: count_d = merge(count_q, bus.i_hwdata, wr_be_q);
        3'd3: cmp_d = merge(cmp_q, bus.i_hwdata, wr_be_q);
`ifdef AHB_TIMER_PRESCALER_EN
        3'd4: prescale_d = PRESCALE_W'(merge(64'(prescale_q), bus.i_hwdata, wr_be_q));
`endif
        default: ;
      endcase
`ifdef AHB_TIMER_PRESCALER_EN
      if (wr_idx_q == 3'd0 || wr_idx_q == 3'd4) div_d = '0;
`endif
    end
    // A match raised this cycle outranks a simultaneous W1C.
    match_d = (match_q & ~w1c) | match_set;
    irq_d   = match_q & ctrl_q[1];

    case (rd_idx_q)
      3'd0: rdata = {61'd0, ctrl_q};
      3'd1: rdata = {63'd0, match_q};
      3'd2: rdata = count_q;
      3'd3: rdata = cmp_q;
`ifdef AHB_TIMER_PRESCALER_EN
      3'd4: rdata = 64'(prescale_q);
`endif
      default: rdata = '0;
    endcase

    if (state_q == ERR1) begin
      state_d  = ERR2;
      hready_d = 1'b1;
      hresp_d  = 1'b1;
    end else begin
      state_d  = IDLE;
      hready_d = 1'b1;
      hresp_d  = 1'b0;
      if (state_q == RD_WAIT) hrdata_d = rdata;
      if (accept) begin
        if (!valid) begin
          state_d  = ERR1;
          hready_d = 1'b0;
          hresp_d  = 1'b1;
        end else if (bus.i_hwrite) begin
          wr_pend_d = 1'b1;
          wr_idx_d  = idx;
          wr_be_d   = be;
        end else begin
          state_d  = RD_WAIT;
          hready_d = 1'b0;
          rd_idx_d = idx;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      hready_q   <= 1'b1;
      hresp_q    <= 1'b0;
      hrdata_q   <= '0;
      irq_q      <= 1'b0;
      ctrl_q     <= '0;
      match_q    <= 1'b0;
      count_q    <= '0;
      cmp_q      <= CMP_RESET;
      wr_pend_q  <= 1'b0;
      wr_idx_q   <= '0;
      wr_be_q    <= '0;
      rd_idx_q   <= '0;
`ifdef AHB_TIMER_PRESCALER_EN
      prescale_q <= '0;
      div_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      hrdata_q   <= hrdata_d;
      irq_q      <= irq_d;
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      wr_pend_q  <= wr_pend_d;
      wr_idx_q   <= wr_idx_d;
      wr_be_q    <= wr_be_d;
      rd_idx_q   <= rd_idx_d;
`ifdef AHB_TIMER_PRESCALER_EN
      prescale_q <= prescale_d;
      div_q      <= div_d;
`endif
    end
  end

  assign bus.o_hready = hready_q;
  assign bus.o_hresp  = hresp_q;
  assign bus.o_hrdata = hrdata_q;
  assign o_irq        = irq_q;

endmodule

// File: tb/tb_ahb_timer.sv
module tb_ahb_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic o_irq;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ahb_timer_if bus();
  assign bus.i_hreadyin = bus.o_hready;

  ahb_timer #(.CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF), .PRESCALE_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_irq(o_irq)
  );

  // Register-level model of the timer
  typedef struct packed {
    logic [2:0]  ctrl;
    logic        match;
    logic [63:0] count;
    logic [63:0] cmp;
    logic [15:0] pres;
    logic [15:0] div;
    logic        irq;
  } mstate_t;

  localparam mstate_t M_RST = '{ctrl: 3'd0, match: 1'b0, count: 64'd0,
                                cmp: 64'hFFFF_FFFF_FFFF_FFFF, pres: 16'd0,
                                div: 16'd0, irq: 1'b0};

  mstate_t     m;
  logic        wr_now = 1'b0;
  logic [5:0]  wr_a = '0;
  logic [2:0]  wr_sz = '0;
  logic [63:0] wr_d = '0;

  function automatic mstate_t step(input mstate_t s, input logic wr, input logic [5:0] a,
                                   input logic [2:0] sz, input logic [63:0] d);
    mstate_t n;
    logic    tk;
    logic    set;
    int      lane;
    n   = s;
    tk  = 1'b1;
    set = 1'b0;
`ifdef AHB_TIMER_PRESCALER_EN
    tk    = (s.div == s.pres);
    n.div = tk ? 16'd0 : s.div + 16'd1;
`endif
    n.irq = s.match & s.ctrl[1];
    if (s.ctrl[0] && tk && !(wr && a[5:3] == 3'd2)) begin
      n.count = s.count + 64'd1;
      if (n.count == s.cmp) begin
        set     = 1'b1;
        n.match = 1'b1;
        if (s.ctrl[2]) n.count = 64'd0;
      end
    end
    if (wr) begin
      for (int b = 0; b < (1 << sz); b++) begin
        lane = int'(a[2:0]) + b;
        case (a[5:3])
          3'd0: if (lane == 0) n.ctrl = d[2:0];
          3'd1: if (lane == 0 && d[0] && !set) n.match = 1'b0;
          3'd2: n.count[8*lane +: 8] = d[8*lane +: 8];
          3'd3: n.cmp[8*lane +: 8] = d[8*lane +: 8];
          3'd4: if (lane < 2) n.pres[8*(lane % 2) +: 8] = d[8*(lane % 2) +: 8];
          default: ;
        endcase
      end
`ifdef AHB_TIMER_PRESCALER_EN
      if (a[5:3] == 3'd0 || a[5:3] == 3'd4) n.div = 16'd0;
`endif
    end
    return n;
  endfunction

  function automatic logic [63:0] mread(input logic [2:0] idx);
    case (idx)
      3'd0:    return {61'd0, m.ctrl};
      3'd1:    return {63'd0, m.match};
      3'd2:    return m.count;
      3'd3:    return m.cmp;
      3'd4:    return {48'd0, m.pres};
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= M_RST;
    else        m <= step(m, wr_now, wr_a, wr_sz, wr_d);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Interrupt output compared with the model on every cycle out of reset.
  always @(negedge clk)
    if (rst_n) check("irq_vs_model", {63'd0, o_irq}, {63'd0, m.irq});

  task automatic drive_addr(input logic [31:0] a, input logic [2:0] sz, input logic w);
    bus.i_hsel = 1'b1; bus.i_haddr = a; bus.i_hsize = sz;
    bus.i_htrans = 2'b10; bus.i_hwrite = w;
  endtask

  task automatic drive_idle();
    bus.i_hsel = 1'b0; bus.i_htrans = 2'b00; bus.i_hwrite = 1'b0;
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d);
    drive_addr(a, sz, 1'b1);
    @(posedge clk); #1;
    drive_idle();
    bus.i_hwdata = d;
    wr_now = 1'b1; wr_a = a[5:0]; wr_sz = sz; wr_d = d;
    check("wr_hready", {63'd0, bus.o_hready}, 64'd1);
    check("wr_hresp",  {63'd0, bus.o_hresp},  64'd0);
    @(posedge clk); #1;
    wr_now = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] lit);
    logic [63:0] exp;
    drive_addr(a, sz, 1'b0);
    @(posedge clk); #1;
    drive_idle();
    check("rd_wait_hready", {63'd0, bus.o_hready}, 64'd0);
    check("rd_wait_hresp",  {63'd0, bus.o_hresp},  64'd0);
    exp = mread(a[5:3]);
    @(posedge clk); #1;
    check("rd_hready", {63'd0, bus.o_hready}, 64'd1);
    check("rd_hresp",  {63'd0, bus.o_hresp},  64'd0);
    check("rd_data_model", bus.o_hrdata, exp);
    check("rd_data_literal", bus.o_hrdata, lit);
  endtask

  task automatic err(input logic [31:0] a, input logic [2:0] sz, input logic w);
    drive_addr(a, sz, w);
    @(posedge clk); #1;
    drive_idle();
    check("err1_hready", {63'd0, bus.o_hready}, 64'd0);
    check("err1_hresp",  {63'd0, bus.o_hresp},  64'd1);
    @(posedge clk); #1;
    check("err2_hready", {63'd0, bus.o_hready}, 64'd1);
    check("err2_hresp",  {63'd0, bus.o_hresp},  64'd1);
    @(posedge clk); #1;
    check("post_err_hready", {63'd0, bus.o_hready}, 64'd1);
    check("post_err_hresp",  {63'd0, bus.o_hresp},  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_hsel = 1'b0; bus.i_haddr = '0; bus.i_hburst = '0; bus.i_hsize = '0;
    bus.i_hprot = '0; bus.i_htrans = '0; bus.i_hwdata = '0; bus.i_hwrite = 1'b0;
    #12;
    check("rst_hready", {63'd0, bus.o_hready}, 64'd1);
    check("rst_hresp",  {63'd0, bus.o_hresp},  64'd0);
    check("rst_hrdata", bus.o_hrdata, 64'd0);
    check("rst_irq",    {63'd0, o_irq}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    rd(32'h18, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(32'h00, 3'd3, 64'd0);
    rd(32'h08, 3'd3, 64'd0);

    // BUSY transfer: zero-wait OKAY
    bus.i_hsel = 1'b1; bus.i_htrans = 2'b01;
    @(posedge clk); #1;
    drive_idle();
    check("busy_hready", {63'd0, bus.o_hready}, 64'd1);
    check("busy_hresp",  {63'd0, bus.o_hresp},  64'd0);

    // Compare match: five ticks after enable, irq one cycle later, W1C
    wr(32'h18, 3'd3, 64'd5);
    wr(32'h00, 3'd3, 64'h3);
    repeat (5) @(posedge clk);
    #1 check("irq_before", {63'd0, o_irq}, 64'd0);
    @(posedge clk); #1;
    check("irq_after", {63'd0, o_irq}, 64'd1);
    rd(32'h08, 3'd3, 64'd1);
    wr(32'h08, 3'd3, 64'd1);
    check("irq_hold_w1c", {63'd0, o_irq}, 64'd1);
    @(posedge clk); #1;
    check("irq_cleared", {63'd0, o_irq}, 64'd0);
    rd(32'h08, 3'd3, 64'd0);
    wr(32'h00, 3'd3, 64'h0);

    // Byte-lane write into COUNT lane 3
    wr(32'h10, 3'd3, 64'h1122_3344_5566_7788);
    wr(32'h13, 3'd0, 64'hDEAD_BEEF_ABCD_EF01);
    rd(32'h10, 3'd3, 64'h1122_3344_AB66_7788);

    // Error responses leave registers untouched
    err(32'h04, 3'd3, 1'b0);
    err(32'h28, 3'd3, 1'b0);
    err(32'h11, 3'd1, 1'b1);
    err(32'h10, 3'd4, 1'b0);
`ifndef AHB_TIMER_PRESCALER_EN
    err(32'h20, 3'd3, 1'b0);
`endif
    rd(32'h10, 3'd3, 64'h1122_3344_AB66_7788);

    // Wrap from all-ones to 0 without match (CMP=5)
    wr(32'h10, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(32'h00, 3'd3, 64'h1);
    wr(32'h00, 3'd3, 64'h0);
    rd(32'h10, 3'd3, 64'd1);
    rd(32'h08, 3'd3, 64'd0);

    // Tick rate
    wr(32'h18, 3'd3, 64'h100);
`ifdef AHB_TIMER_PRESCALER_EN
    wr(32'h20, 3'd1, 64'd3);
    rd(32'h20, 3'd3, 64'd3);
`endif
    wr(32'h10, 3'd3, 64'd0);
    wr(32'h00, 3'd3, 64'h1);
    repeat (10) @(posedge clk);
    #1;
    wr(32'h00, 3'd3, 64'h0);
`ifdef AHB_TIMER_PRESCALER_EN
    rd(32'h10, 3'd3, 64'd3);
`else
    rd(32'h10, 3'd3, 64'd12);
`endif

    // Reset in the middle of a read wait state
    drive_addr(32'h18, 3'd3, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_hready", {63'd0, bus.o_hready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    drive_idle();
    check("midrst_hready", {63'd0, bus.o_hready}, 64'd1);
    check("midrst_hresp",  {63'd0, bus.o_hresp},  64'd0);
    check("midrst_hrdata", bus.o_hrdata, 64'd0);
    check("midrst_irq",    {63'd0, o_irq}, 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h18, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(32'h10, 3'd3, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/ahb_timer.md
AHB_TIMER -- requirements
Module: ahb_timer

Interface
REQ-001 SHALL have parameter CMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF, giving the reset value of CMP.
REQ-002 SHALL have parameter PRESCALE_W, default 16, giving the width of the PRESCALE register.
REQ-003 One clock; reset is asynchronous and active-low.
- i_clk  in  1  sole clock (bus clock).
- i_rst_n  in  1  async active-low reset.
REQ-004 SHALL have AHB-Lite responder inputs:
- i_hsel  in  1  select.
- i_haddr  in  32  address; only [5:0] decoded.
- i_hburst  in  3  ignored.
- i_hsize  in  3  transfer size.
- i_hprot  in  4  ignored.
- i_htrans  in  2  transfer type.
- i_hwdata  in  64  write data.
- i_hwrite  in  1  write.
- i_hreadyin  in  1  bus-level HREADY.
REQ-005 SHALL have outputs:
- o_hrdata  out  64  read data.
- o_hresp  out  1  1 = ERROR.
- o_hready  out  1  transfer done.
- o_irq  out  1  compare interrupt, registered.

Function
REQ-006 Address phase SHALL be accepted when i_hsel & i_hreadyin & i_htrans[1]; IDLE/BUSY SHALL get zero-wait OKAY.
REQ-007 Register map (64-bit):
- 0x00 CTRL: [0] enable, [1] irq_en, [2] clear_on_match.
- 0x08 STATUS: [0] match, write-1-to-clear.
- 0x10 COUNT: RW.
- 0x18 CMP: RW.
- 0x20 PRESCALE: see Configuration.
REQ-008 Writes SHALL complete with zero wait states; data SHALL be applied at the end of the data phase, updating only the byte lanes selected by haddr[2:0] and hsize.
REQ-009 Reads SHALL insert exactly one wait state (o_hready=0 for one cycle); the registered full 64-bit register value SHALL be on o_hrdata when o_hready=1.
REQ-010 Unmapped offset, hsize>3, or haddr misaligned to hsize SHALL produce a two-cycle ERROR: cycle 1 hresp=1/hready=0, cycle 2 hresp=1/hready=1; no register changes.
REQ-011 Responder state machine SHALL have states IDLE, RD_WAIT, ERR1, ERR2.
- IDLE->RD_WAIT on an accepted valid read.
- IDLE->ERR1 on an accepted invalid transfer.
- ERR1->ERR2 unconditionally.
- RD_WAIT, ERR2 -> IDLE, or accept a pipelined next transfer.
REQ-012 When enable=1 and a tick occurs, COUNT SHALL increment by 1, wrapping 2^64-1 -> 0.
REQ-013 Match SHALL be when the incremented value equals CMP; it SHALL set STATUS.match, and if clear_on_match=1 COUNT SHALL load 0 instead.
REQ-014 A bus write to COUNT in the same cycle as an increment SHALL win.
REQ-015 A match set in the same cycle as a W1C SHALL leave match=1.
REQ-016 o_irq SHALL equal the registered value of STATUS.match & irq_en, lagging by one cycle.

Reset
REQ-017 On i_rst_n=0, immediately:
- CTRL=0, STATUS=0, COUNT=0, CMP=CMP_RESET, PRESCALE=0.
- State=IDLE.
- o_hready=1, o_hresp=0, o_hrdata=0, o_irq=0.
REQ-018 Reset mid-transfer SHALL abort it; the first transfer after deassertion SHALL be accepted normally.

Configuration
REQ-019 Macro AHB_TIMER_PRESCALER_EN:
- Defined: PRESCALE is RW at 0x20; a PRESCALE_W-bit divider issues a tick every PRESCALE+1 cycles; the divider resets to 0 on any write to CTRL or PRESCALE.
- Undefined: tick every cycle; 0x20 is unmapped and returns ERROR.

Verification
REQ-020 Bench SHALL cover:
- Reset, then read CMP at 0x18 -> one wait state, hrdata=64'hFFFF_FFFF_FFFF_FFFF, OKAY.
- Write CMP=5, CTRL=0x3 -> STATUS.match=1 five ticks after enable; o_irq=1 one cycle later; W1C 0x08 data 1 -> o_irq=0.
- Byte write hsize=0 at 0x13 data 0xAB in lane 3 -> COUNT[31:24]=0xAB, other bytes unchanged.
- Read 0x04 hsize=3 (misaligned), and 0x28 -> two-cycle ERROR each; registers unchanged.
- COUNT=64'hFFFF_FFFF_FFFF_FFFF, enable -> COUNT=0 next tick with no match (CMP=5).
- With the macro defined, PRESCALE=3 -> COUNT increments every 4 cycles; without it, every cycle.
